temporizador_mmss: RTL and testbench
====================================

TEMPORIZADOR_MMSS -- requirements
Module: temporizador_mmss

Interface
REQ-001 SHALL have parameter MIN_DIGITS, default 2: number of BCD minute digits, legal range 1..3.
REQ-002 SHALL have parameter CLK_DIV, default 50000000: clock cycles per count tick, legal range >=1.
REQ-003 SHALL have parameter AUTO_RELOAD, default 0: 1 selects periodic reload at terminal count.
REQ-004 SHALL have parameter RST_MIN, default 1: reset value of the minute count and preset, binary 0..10^MIN_DIGITS-1.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port load, input, 1 bit: capture preset and load it into the count.
REQ-008 SHALL have port start, input, 1 bit: begin or resume counting.
REQ-009 SHALL have port stop, input, 1 bit: pause counting.
REQ-010 SHALL have port up, input, 1 bit: direction, 0 = count down, 1 = count up; sampled on every tick.
REQ-011 SHALL have port preset_min, input, 4*MIN_DIGITS bits: BCD minute preset.
REQ-012 SHALL have port preset_sec, input, 7 bits: [6:4] seconds tens, [3:0] seconds units.
REQ-013 SHALL have port min_bcd, output, 4*MIN_DIGITS bits: BCD minute count, digit 0 in [3:0].
REQ-014 SHALL have port sec_t, output, 3 bits: seconds tens, 0..5.
REQ-015 SHALL have port sec_u, output, 4 bits: seconds units, 0..9.
REQ-016 SHALL have port running, output, 1 bit: high while in RUN.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at terminal count.
REQ-018 SHALL have port expired, output, 1 bit: high while in DONE.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, PAUSE and DONE.
REQ-020 Priority per cycle SHALL be load > stop > start; when load is high, all other inputs are ignored for that cycle.
REQ-021 load in any state SHALL do all of the following at the next edge: capture the preset into the preset register, copy it into the count, clear the prescaler, go to IDLE.
REQ-022 Preset saturation: any BCD digit >9 SHALL be stored as 9, and a seconds tens value >5 SHALL be stored as 5.
REQ-023 start in IDLE or PAUSE SHALL move to RUN at the next edge.
REQ-024 When start is accepted and the count already equals the terminal value for the current up setting, the FSM SHALL go to DONE instead of RUN and pulse done.
REQ-025 stop in RUN SHALL move to PAUSE at the next edge; the count and prescaler SHALL hold.
REQ-026 stop in IDLE, PAUSE or DONE SHALL have no effect; start in RUN or DONE SHALL have no effect.
REQ-027 Prescaler SHALL count 0..CLK_DIV-1 only in RUN; tick is asserted when the prescaler equals CLK_DIV-1, after which it wraps to 0.
REQ-028 The prescaler SHALL be cleared on entry to RUN from IDLE; it SHALL resume its held value when leaving PAUSE.
REQ-029 Each tick SHALL update the count once on that edge (with CLK_DIV=1, every RUN cycle).
REQ-030 Down counting: sec_u 0->9 with borrow into sec_t; sec_t 0->5 with borrow into minute digit 0; each minute digit 0->9 with borrow into the next digit.
REQ-031 Up counting: sec_u 9->0 with carry; sec_t 5->0 with carry; each minute digit 9->0 with carry into the next digit.
REQ-032 Terminal value SHALL be all zeros when counting down, and all minute digits 9 with seconds 59 when counting up.
REQ-033 With AUTO_RELOAD=0, the tick that produces the terminal value SHALL load that value, enter DONE, and assert done for exactly the first DONE cycle.
REQ-034 With AUTO_RELOAD=1, the tick that would produce the terminal value SHALL instead load the preset register, stay in RUN and pulse done; the period is therefore preset ticks.
REQ-035 DONE SHALL hold the count until load is asserted; expired = (state==DONE), running = (state==RUN).
REQ-036 A change on up while in RUN SHALL take effect at the next tick, with no glitch in the count.

Reset
REQ-037 When reset is low, the block SHALL immediately go to IDLE: count = RST_MIN minutes (as BCD) and 0 seconds, preset register equal to the same value, prescaler 0, done/expired/running 0.
REQ-038 Reset assertion mid-RUN SHALL abort without a done pulse; leaving reset SHALL require start to resume counting.

Verification
REQ-039 CLK_DIV=1, MIN_DIGITS=2, AUTO_RELOAD=0: reset release then start -> 01:00, 00:59, ..., 00:00 over 60 cycles; done high for exactly 1 cycle; expired stays high.
REQ-040 Load with preset 10:00, start, run 1 tick -> 09:59; then load 00:00 with up=0, start -> DONE next edge with a done pulse.
REQ-041 Up counting from load 99:58 -> 99:59 with DONE; preset 7F/0xFF -> saturated and stored as 99:59.
REQ-042 CLK_DIV=4: start, stop after 2 cycles, wait 10 cycles, start -> first decrement occurs 2 RUN cycles after resume; load, stop and start together -> load wins, state IDLE.
REQ-043 AUTO_RELOAD=1 with preset 00:03, down -> count 00:02, 00:01, 00:03, ...; done pulses every 3 ticks; running stays 1.
REQ-044 Reset pulsed low mid-count at 00:30 -> 01:00, IDLE, no done pulse; done/running/expired stay 0 until start.

Source files
------------

// File: rtl/temporizador_mmss.sv
// rtl/temporizador_mmss.sv - MM:SS BCD up/down timer with pause, preset load and optional auto-reload
module temporizador_mmss #(
    parameter int MIN_DIGITS  = 2,
    parameter int CLK_DIV     = 50000000,
    parameter bit AUTO_RELOAD = 1'b0,
    parameter int RST_MIN     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    up,
    input  logic [4*MIN_DIGITS-1:0] preset_min,
    input  logic [6:0]              preset_sec,
    output logic [4*MIN_DIGITS-1:0] min_bcd,
    output logic [2:0]              sec_t,
    output logic [3:0]              sec_u,
    output logic                    running,
    output logic                    done,
    output logic                    expired
);
    localparam int MW = 4 * MIN_DIGITS;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

    function automatic logic [MW-1:0] to_bcd(input int v);
        logic [MW-1:0] b;
        int r;
        b = '0;
        r = v;
        for (int i = 0; i < MIN_DIGITS; i++) begin
            b[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
        return b;
    endfunction

    localparam logic [MW-1:0] RST_BCD   = to_bcd(RST_MIN);
    localparam logic [MW-1:0] ALL_NINES = to_bcd(10 ** MIN_DIGITS - 1);

    function automatic logic is_term(input logic [MW-1:0] m, input logic [2:0] t,
                                     input logic [3:0] u, input logic dir_up);
        if (dir_up)
            return (m == ALL_NINES) && (t == 3'd5) && (u == 4'd9);
        else
            return (m == '0) && (t == 3'd0) && (u == 4'd0);
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t        state;
    logic [MW-1:0] min_q, pre_min;
    logic [2:0]    st_q, pre_st;
    logic [3:0]    su_q, pre_su;
    logic [PW-1:0] presc;

    logic [MW-1:0] sat_min, nmin;
    logic [2:0]    sat_st, nst;
    logic [3:0]    sat_su, nsu;
    logic          cy;
    logic          tick, at_term, nxt_term;

    always_comb begin
        sat_min = preset_min;
        for (int i = 0; i < MIN_DIGITS; i++)
            if (preset_min[4*i +: 4] > 4'd9) sat_min[4*i +: 4] = 4'd9;
        sat_st = (preset_sec[6:4] > 3'd5) ? 3'd5 : preset_sec[6:4];
        sat_su = (preset_sec[3:0] > 4'd9) ? 4'd9 : preset_sec[3:0];
    end

    // Ripple carry/borrow through sec_u -> sec_t -> minute digits; wraps past the top digit
    always_comb begin
        nmin = min_q;
        nst  = st_q;
        nsu  = su_q;
        cy   = 1'b1;
        if (up) begin
            if (su_q == 4'd9) nsu = 4'd0; else begin nsu = su_q + 4'd1; cy = 1'b0; end
            if (cy) begin
                if (st_q == 3'd5) nst = 3'd0; else begin nst = st_q + 3'd1; cy = 1'b0; end
            end
            for (int i = 0; i < MIN_DIGITS; i++) begin
                if (cy) begin
                    if (min_q[4*i +: 4] == 4'd9) nmin[4*i +: 4] = 4'd0;
                    else begin nmin[4*i +: 4] = min_q[4*i +: 4] + 4'd1; cy = 1'b0; end
                end
            end
        end else begin
            if (su_q == 4'd0) nsu = 4'd9; else begin nsu = su_q - 4'd1; cy = 1'b0; end
            if (cy) begin
                if (st_q == 3'd0) nst = 3'd5; else begin nst = st_q - 3'd1; cy = 1'b0; end
            end
            for (int i = 0; i < MIN_DIGITS; i++) begin
                if (cy) begin
                    if (min_q[4*i +: 4] == 4'd0) nmin[4*i +: 4] = 4'd9;
                    else begin nmin[4*i +: 4] = min_q[4*i +: 4] - 4'd1; cy = 1'b0; end
                end
            end
        end
    end

    assign tick     = (presc == PS_LAST);
    assign at_term  = is_term(min_q, st_q, su_q, up);
    assign nxt_term = is_term(nmin, nst, nsu, up);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            min_q   <= RST_BCD;
            st_q    <= 3'd0;
            su_q    <= 4'd0;
            pre_min <= RST_BCD;
            pre_st  <= 3'd0;
            pre_su  <= 4'd0;
            presc   <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                pre_min <= sat_min;
                pre_st  <= sat_st;
                pre_su  <= sat_su;
                min_q   <= sat_min;
                st_q    <= sat_st;
                su_q    <= sat_su;
                presc   <= '0;
                state   <= IDLE;
            end else begin
                case (state)
                    IDLE, PAUSE: begin
                        // stop outranks start even though stop alone does nothing here
                        if (start && !stop) begin
                            if (at_term) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                if (state == IDLE) presc <= '0;
                                state <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            state <= PAUSE;
                        end else if (tick) begin
                            presc <= '0;
                            if (nxt_term && AUTO_RELOAD) begin
                                min_q <= pre_min;
                                st_q  <= pre_st;
                                su_q  <= pre_su;
                                done  <= 1'b1;
                            end else begin
                                min_q <= nmin;
                                st_q  <= nst;
                                su_q  <= nsu;
                                if (nxt_term) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign min_bcd = min_q;
    assign sec_t   = st_q;
    assign sec_u   = su_q;
    assign running = (state == RUN);
    assign expired = (state == DONE);
endmodule

// File: tb/tb_temporizador_mmss.sv
// tb/tb_temporizador_mmss.sv - directed and random checks of temporizador_mmss against a total-seconds model
module tb_temporizador_mmss;
    localparam int MD   = 2;
    localparam int MAXT = 6000;
    localparam int N    = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic clk = 1'b0;
    logic reset, load, start, stop, up;
    logic [4*MD-1:0] preset_min;
    logic [6:0]      preset_sec;

    logic [N-1:0][4*MD-1:0] o_min;
    logic [N-1:0][2:0]      o_st;
    logic [N-1:0][3:0]      o_su;
    logic [N-1:0]           o_run, o_done, o_exp;

    int passed = 0;
    int total  = 0;

    int m_state [N];
    int m_cnt   [N];
    int m_pre   [N];
    int m_ps    [N];
    bit m_done  [N];

    always #5 clk = ~clk;

    temporizador_mmss #(.MIN_DIGITS(MD), .CLK_DIV(1), .AUTO_RELOAD(1'b0), .RST_MIN(1)) u_a (
        .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop), .up(up),
        .preset_min(preset_min), .preset_sec(preset_sec),
        .min_bcd(o_min[0]), .sec_t(o_st[0]), .sec_u(o_su[0]),
        .running(o_run[0]), .done(o_done[0]), .expired(o_exp[0]));

    temporizador_mmss #(.MIN_DIGITS(MD), .CLK_DIV(4), .AUTO_RELOAD(1'b0), .RST_MIN(1)) u_b (
        .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop), .up(up),
        .preset_min(preset_min), .preset_sec(preset_sec),
        .min_bcd(o_min[1]), .sec_t(o_st[1]), .sec_u(o_su[1]),
        .running(o_run[1]), .done(o_done[1]), .expired(o_exp[1]));

    temporizador_mmss #(.MIN_DIGITS(MD), .CLK_DIV(1), .AUTO_RELOAD(1'b1), .RST_MIN(1)) u_c (
        .clk(clk), .reset(reset), .load(load), .start(start), .stop(stop), .up(up),
        .preset_min(preset_min), .preset_sec(preset_sec),
        .min_bcd(o_min[2]), .sec_t(o_st[2]), .sec_u(o_su[2]),
        .running(o_run[2]), .done(o_done[2]), .expired(o_exp[2]));

    function automatic int cdiv(input int i);
        return (i == 1) ? 4 : 1;
    endfunction

    function automatic bit car(input int i);
        return (i == 2);
    endfunction

    function automatic int preset_total();
        int mins, scale, d, t, u;
        mins  = 0;
        scale = 1;
        for (int k = 0; k < MD; k++) begin
            d = int'(preset_min[4*k +: 4]);
            if (d > 9) d = 9;
            mins  = mins + d * scale;
            scale = scale * 10;
        end
        t = int'(preset_sec[6:4]);
        if (t > 5) t = 5;
        u = int'(preset_sec[3:0]);
        if (u > 9) u = 9;
        return mins * 60 + t * 10 + u;
    endfunction

    task automatic model_reset(input int i);
        m_state[i] = S_IDLE;
        m_cnt[i]   = 60;
        m_pre[i]   = 60;
        m_ps[i]    = 0;
        m_done[i]  = 1'b0;
    endtask

    task automatic model_step(input int i);
        int term, nxt;
        term      = up ? MAXT - 1 : 0;
        m_done[i] = 1'b0;
        if (!reset) begin
            model_reset(i);
        end else if (load) begin
            m_pre[i]   = preset_total();
            m_cnt[i]   = m_pre[i];
            m_ps[i]    = 0;
            m_state[i] = S_IDLE;
        end else if ((m_state[i] == S_IDLE || m_state[i] == S_PAUSE) && start && !stop) begin
            if (m_cnt[i] == term) begin
                m_state[i] = S_DONE;
                m_done[i]  = 1'b1;
            end else begin
                if (m_state[i] == S_IDLE) m_ps[i] = 0;
                m_state[i] = S_RUN;
            end
        end else if (m_state[i] == S_RUN && stop) begin
            m_state[i] = S_PAUSE;
        end else if (m_state[i] == S_RUN) begin
            if (m_ps[i] < cdiv(i) - 1) begin
                m_ps[i] = m_ps[i] + 1;
            end else begin
                m_ps[i] = 0;
                nxt = (m_cnt[i] + (up ? 1 : MAXT - 1)) % MAXT;
                if (nxt == term) begin
                    m_done[i] = 1'b1;
                    if (car(i)) m_cnt[i] = m_pre[i];
                    else begin
                        m_cnt[i]   = nxt;
                        m_state[i] = S_DONE;
                    end
                end else begin
                    m_cnt[i] = nxt;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
    endtask

    task automatic check_all();
        int mins, secs;
        for (int i = 0; i < N; i++) begin
            mins = m_cnt[i] / 60;
            secs = m_cnt[i] % 60;
            chk("min_bcd", i, 32'(o_min[i]), 32'(((mins / 10) << 4) | (mins % 10)));
            chk("sec_t",   i, 32'(o_st[i]),  32'(secs / 10));
            chk("sec_u",   i, 32'(o_su[i]),  32'(secs % 10));
            chk("running", i, 32'(o_run[i]), 32'(m_state[i] == S_RUN));
            chk("expired", i, 32'(o_exp[i]), 32'(m_state[i] == S_DONE));
            chk("done",    i, 32'(o_done[i]), 32'(m_done[i]));
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            for (int i = 0; i < N; i++) model_step(i);
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic step(input bit l, input bit s, input bit p);
        load  = l;
        start = s;
        stop  = p;
        tick_n(1);
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic set_preset(input logic [7:0] m, input logic [6:0] s);
        preset_min = m;
        preset_sec = s;
    endtask

    initial begin
        reset = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; up = 1'b0;
        set_preset(8'h00, 7'h00);
        @(negedge clk);
        for (int i = 0; i < N; i++) model_reset(i);
        check_all();
        tick_n(2);
        reset = 1'b1;
        tick_n(2);

        // 01:00 down to 00:00, then DONE holds
        step(0, 1, 0);
        tick_n(62);

        // 10:00 one tick, then start on a terminal 00:00
        set_preset(8'h10, 7'h00);
        step(1, 0, 0);
        step(0, 1, 0);
        tick_n(1);
        set_preset(8'h00, 7'h00);
        step(1, 0, 0);
        step(0, 1, 0);
        tick_n(2);

        // up count into 99:59, then saturating preset
        up = 1'b1;
        set_preset(8'h99, 7'h58);
        step(1, 0, 0);
        step(0, 1, 0);
        tick_n(3);
        set_preset(8'hFF, 7'h7F);
        step(1, 0, 0);
        tick_n(1);
        step(0, 1, 0);
        tick_n(1);

        // pause with held prescaler, then load beating stop and start
        up = 1'b0;
        set_preset(8'h00, 7'h20);
        step(1, 0, 0);
        step(0, 1, 0);
        tick_n(1);
        step(0, 0, 1);
        tick_n(10);
        step(0, 1, 0);
        tick_n(4);
        step(1, 1, 1);
        tick_n(1);

        // auto-reload period of 3 ticks
        set_preset(8'h00, 7'h03);
        step(1, 0, 0);
        step(0, 1, 0);
        tick_n(10);

        // asynchronous reset in the middle of a count
        set_preset(8'h00, 7'h40);
        step(1, 0, 0);
        step(0, 1, 0);
        tick_n(9);
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) model_reset(i);
        check_all();
        tick_n(2);
        reset = 1'b1;
        tick_n(3);

        repeat (600) begin
            reset = ($urandom_range(0, 99) != 0);
            load  = ($urandom_range(0, 19) == 0);
            stop  = ($urandom_range(0, 9) == 0);
            start = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0) up = ~up;
            if ($urandom_range(0, 3) == 0)
                set_preset(8'($urandom), 7'($urandom));
            else
                set_preset({4'h0, 4'($urandom_range(0, 1))}, 7'($urandom));
            tick_n(1);
        end
        reset = 1'b1; load = 1'b0; start = 1'b0; stop = 1'b0;
        tick_n(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
